// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: mode/state encodings and sequence-table helpers for the 3-bit sequence counter.
//   seq_start(m)      first value of sequence m
//   seq_terminal(m)   last value of sequence m (before wrap)
//   seq_legal(m, v)   1 when v is a member of sequence m
package cnt_seq_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_ODD  = 2'b10,
        MODE_GRAY = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic [CNT_W-1:0] seq_start(mode_e m);
        return (m == MODE_DOWN) ? 3'd7 : 3'd0;
    endfunction

    function automatic logic [CNT_W-1:0] seq_terminal(mode_e m);
        return (m == MODE_DOWN) ? 3'd0 : (m == MODE_GRAY) ? 3'd4 : 3'd7;
    endfunction

    // Only odd-skip has holes: 2, 4 and 6 never appear in it.
    function automatic logic seq_legal(mode_e m, logic [CNT_W-1:0] v);
        return (m != MODE_ODD) || (v == '0) || v[0];
    endfunction

endpackage

// File: rtl/seq_next_logic.sv
// seq_next_logic: combinational successor of a count value under a sequence mode.
//   count_i  present count
//   mode_i   sequence mode
//   nxt_o    successor value (out-of-sequence odd-skip values map to 0)
module seq_next_logic
    import cnt_seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] count_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] nxt_o
);
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_inc;
    logic [WIDTH-1:0] odd_nxt;

    // Gray successor: decode to binary, increment, re-encode.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) bin[i] = ^(count_i >> i);
    end

    assign bin_inc = bin + WIDTH'(1);

    // 0 -> 1, odd -> odd+2, top value and even holes -> 0.
    assign odd_nxt = (count_i == '0) ? WIDTH'(1) :
                     (!count_i[0] || count_i == '1) ? '0 : count_i + WIDTH'(2);

    assign nxt_o = (mode_i == MODE_UP)   ? count_i + WIDTH'(1) :
                   (mode_i == MODE_DOWN) ? count_i - WIDTH'(1) :
                   (mode_i == MODE_ODD)  ? odd_nxt :
                                           bin_inc ^ (bin_inc >> 1);

endmodule

// File: rtl/count_seq_controller.sv
// count_seq_controller: start/stop/pause sequencer for a 3-bit multi-sequence counter.
//   clk, rst (async, active-low)
//   start/stop/pause/one_shot/load/load_val/mode  run commands (start/load/mode/one_shot used in IDLE only)
//   count  registered count       nxt      successor under the active mode
//   busy   RUN state              tc       terminal value reached while running
//   done   one-cycle one-shot end illegal  one-cycle pulse after correcting an out-of-sequence value
module count_seq_controller
    import cnt_seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             one_shot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] nxt,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic             illegal
);
    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    mode_e            act_mode;
    logic             one_shot_q, one_shot_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] cand;

    assign act_mode = (state_q == ST_IDLE) ? mode_e'(mode) : mode_q;

    seq_next_logic #(.WIDTH(WIDTH)) u_next (
        .count_i(count_q),
        .mode_i (act_mode),
        .nxt_o  (nxt)
    );

    // Value a run would begin from: a coincident load wins over the held count.
    assign cand = load ? load_val : count_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mode_d     = mode_q;
        one_shot_d = one_shot_q;
        illegal_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load || start) begin
                    count_d   = seq_legal(mode_e'(mode), cand) ? cand : seq_start(mode_e'(mode));
                    illegal_d = !seq_legal(mode_e'(mode), cand);
                end
                if (start) begin
                    mode_d     = mode_e'(mode);
                    one_shot_d = one_shot;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    if (one_shot_q && count_q == seq_terminal(mode_q)) state_d = ST_DONE;
                    else count_d = nxt;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            mode_q     <= MODE_UP;
            one_shot_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            one_shot_q <= one_shot_d;
            illegal_q  <= illegal_d;
        end
    end

    assign count   = count_q;
    assign busy    = (state_q == ST_RUN);
    assign tc      = busy && (count_q == seq_terminal(mode_q));
    assign done    = (state_q == ST_DONE);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_count_seq_controller.sv
// tb_count_seq_controller: directed and randomized checks of count_seq_controller against a table-driven model.
module tb_count_seq_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, one_shot = 1'b0, load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic [1:0] mode = 2'd0;
    logic [2:0] count, nxt;
    logic       busy, tc, done, illegal;
    int         vecs = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    count_seq_controller #(.WIDTH(3)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .one_shot(one_shot), .load(load), .load_val(load_val), .mode(mode),
        .count(count), .nxt(nxt), .busy(busy), .tc(tc), .done(done), .illegal(illegal)
    );

    // Reference model: each mode is an ordered list of values; successor is the next list entry.
    logic [2:0] tab[4][8];
    int         len[4];
    int         m_st;
    logic [2:0] m_cnt;
    int         m_mode;
    logic       m_os, m_ill;

    function automatic int pos(int md, logic [2:0] v);
        for (int i = 0; i < len[md]; i++) if (tab[md][i] == v) return i;
        return -1;
    endfunction

    function automatic logic [2:0] succ(int md, logic [2:0] v);
        int p = pos(md, v);
        return (p < 0) ? 3'd0 : tab[md][(p + 1) % len[md]];
    endfunction

    function automatic logic [2:0] term(int md);
        return tab[md][len[md] - 1];
    endfunction

    function automatic logic [9:0] mexp();
        int am = (m_st == 0) ? int'(mode) : m_mode;
        return {m_cnt, succ(am, m_cnt), m_st == 1, m_st == 1 && m_cnt == term(m_mode), m_st == 2, m_ill};
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 3'd0; m_mode = 0; m_os = 1'b0; m_ill = 1'b0;
    endtask

    task automatic model_update();
        logic [2:0] c;
        m_ill = 1'b0;
        if (m_st == 0) begin
            c = load ? load_val : m_cnt;
            if (load || start) begin
                m_ill = pos(int'(mode), c) < 0;
                m_cnt = m_ill ? tab[int'(mode)][0] : c;
            end
            if (start) begin
                m_mode = int'(mode); m_os = one_shot; m_st = 1;
            end
        end else if (m_st == 1) begin
            if (stop) m_st = 0;
            else if (!pause) begin
                if (m_os && m_cnt == term(m_mode)) m_st = 2;
                else m_cnt = succ(m_mode, m_cnt);
            end
        end else begin
            m_st = 0;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; pause = 0; load = 0; one_shot = 0;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        #1;
        obs = {count, nxt, busy, tc, done, illegal};
        vecs++;
        if (obs !== 10'b000_001_0000) begin errs++; $display("FAIL reset_async: got %b want %b", obs, 10'b000_001_0000); end
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        obs = {count, nxt, busy, tc, done, illegal};
        vecs++;
        if (obs !== mexp()) begin errs++; $display("FAIL reset_held: got %b want %b", obs, mexp()); end
        rst = 1;
        tick();
        obs = {count, nxt, busy, tc, done, illegal};
        vecs++;
        if (obs !== mexp()) begin errs++; $display("FAIL reset_release: got %b want %b", obs, mexp()); end
    endtask

    task automatic test_odd_continuous();
        logic [2:0] exp_c[7] = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd1};
        logic [9:0] obs;
        mode = 2'b10; start = 1;
        tick();
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            obs = {count, nxt, busy, tc, done, illegal};
            vecs++;
            if ({count, busy, tc, done} !== {exp_c[i], 1'b1, exp_c[i] == 3'd7, 1'b0}) begin
                errs++; $display("FAIL odd_step%0d: got count=%0d busy=%b tc=%b done=%b want count=%0d", i, count, busy, tc, done, exp_c[i]);
            end
            vecs++;
            if (obs !== mexp()) begin errs++; $display("FAIL odd_model%0d: got %b want %b", i, obs, mexp()); end
            tick();
        end
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic test_gray_oneshot();
        logic [2:0] exp_c[10] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd4, 3'd4};
        logic [9:0] obs;
        mode = 2'b11; one_shot = 1; load = 1; load_val = 3'd0; start = 1;
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            obs = {count, nxt, busy, tc, done, illegal};
            vecs++;
            if ({count, busy, tc, done} !== {exp_c[i], i < 8, i == 7, i == 8}) begin
                errs++; $display("FAIL gray_step%0d: got count=%0d busy=%b tc=%b done=%b want count=%0d", i, count, busy, tc, done, exp_c[i]);
            end
            vecs++;
            if (obs !== mexp()) begin errs++; $display("FAIL gray_model%0d: got %b want %b", i, obs, mexp()); end
            tick();
        end
    endtask

    task automatic test_down_load();
        logic [2:0] exp_c[8] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
        logic [9:0] obs;
        mode = 2'b01; load = 1; load_val = 3'd5; start = 1;
        tick();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            obs = {count, nxt, busy, tc, done, illegal};
            vecs++;
            if ({count, tc} !== {exp_c[i], exp_c[i] == 3'd0}) begin
                errs++; $display("FAIL down_step%0d: got count=%0d tc=%b want count=%0d", i, count, tc, exp_c[i]);
            end
            vecs++;
            if (obs !== mexp()) begin errs++; $display("FAIL down_model%0d: got %b want %b", i, obs, mexp()); end
            tick();
        end
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic test_illegal_load();
        logic [2:0] exp_c[3] = '{3'd0, 3'd1, 3'd3};
        mode = 2'b10; load = 1; load_val = 3'd4;
        tick();
        load = 0;
        vecs++;
        if ({count, illegal, busy} !== {3'd0, 1'b1, 1'b0}) begin
            errs++; $display("FAIL illegal_load: got count=%0d illegal=%b busy=%b want count=0 illegal=1 busy=0", count, illegal, busy);
        end
        tick();
        vecs++;
        if (illegal !== 1'b0) begin errs++; $display("FAIL illegal_pulse_width: got %b want 0", illegal); end
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if ({count, illegal} !== {exp_c[i], 1'b0}) begin
                errs++; $display("FAIL illegal_run%0d: got count=%0d illegal=%b want count=%0d", i, count, illegal, exp_c[i]);
            end
            tick();
        end
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic test_priority();
        logic [9:0] obs;
        mode = 2'b00; load = 1; load_val = 3'd0; start = 1;
        tick();
        idle_inputs();
        repeat (3) tick();
        vecs++;
        if (count !== 3'd3) begin errs++; $display("FAIL prio_reach3: got %0d want 3", count); end
        pause = 1; start = 1; mode = 2'b01; load = 1; load_val = 3'd6;
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if ({count, busy, tc} !== {3'd3, 1'b1, 1'b0}) begin
                errs++; $display("FAIL prio_pause%0d: got count=%0d busy=%b tc=%b want count=3 busy=1 tc=0", i, count, busy, tc);
            end
        end
        start = 0; load = 0;
        stop = 1;
        tick();
        obs = {count, nxt, busy, tc, done, illegal};
        vecs++;
        if ({count, busy, done} !== {3'd3, 1'b0, 1'b0}) begin
            errs++; $display("FAIL prio_stop: got count=%0d busy=%b done=%b want count=3 busy=0 done=0", count, busy, done);
        end
        vecs++;
        if (obs !== mexp()) begin errs++; $display("FAIL prio_model: got %b want %b", obs, mexp()); end
        idle_inputs();
        tick();
        vecs++;
        if (done !== 1'b0) begin errs++; $display("FAIL prio_nodone: got %b want 0", done); end
    endtask

    task automatic test_reset_midrun();
        logic [9:0] obs;
        mode = 2'b00; load = 1; load_val = 3'd0; start = 1;
        tick();
        idle_inputs();
        repeat (5) tick();
        vecs++;
        if (count !== 3'd5) begin errs++; $display("FAIL midrun_reach5: got %0d want 5", count); end
        #2 rst = 0;
        #1;
        model_reset();
        vecs++;
        if ({count, busy, tc, done} !== 6'b000_000) begin
            errs++; $display("FAIL midrun_async: got count=%0d busy=%b tc=%b done=%b want all 0", count, busy, tc, done);
        end
        #1 rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {count, nxt, busy, tc, done, illegal};
            vecs++;
            if (obs !== mexp() || done !== 1'b0) begin errs++; $display("FAIL midrun_after%0d: got %b want %b", i, obs, mexp()); end
        end
    endtask

    task automatic test_random();
        logic [9:0] obs;
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            pause    = ($urandom_range(0, 7) == 0);
            load     = ($urandom_range(0, 5) == 0);
            one_shot = $urandom_range(0, 1) == 1;
            load_val = 3'($urandom_range(0, 7));
            mode     = 2'($urandom_range(0, 3));
            tick();
            obs = {count, nxt, busy, tc, done, illegal};
            vecs++;
            if (obs !== mexp()) begin errs++; $display("FAIL random%0d: got %b want %b", i, obs, mexp()); end
        end
        idle_inputs();
    endtask

    initial begin
        tab[0] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        tab[1] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        tab[2] = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0};
        tab[3] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        len    = '{8, 8, 5, 8};
        model_reset();
        test_reset();
        test_odd_continuous();
        test_gray_oneshot();
        test_down_load();
        test_illegal_load();
        test_priority();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/count_seq_controller.md
Name: count_seq_controller

Overview:
- Sequencing controller for the lab's 3-bit multi-sequence counter datapath.
- Accepts start/stop/pause commands and a sequence mode, then steps the count register through the selected sequence.
- Flags the terminal value and supports continuous or one-shot runs.
- Used by the top-level lab harness that drives counters from switches and displays count/nxt on LEDs.

Parameters:
WIDTH, 3, counter width; the sequence tables are defined for 3 bits only, other values unsupported.

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-low
start  input  1  begin run (sampled in IDLE only)
stop  input  1  abort run, return to IDLE
pause  input  1  hold count while in RUN
one_shot  input  1  1 = stop after terminal value; sampled with start
load  input  1  load load_val into count (IDLE only)
load_val  input  WIDTH  value to load
mode  input  2  00 binary up, 01 binary down, 10 odd-skip, 11 gray; sampled with start
count  output  WIDTH  present count value (registered)
nxt  output  WIDTH  successor of count under the active mode (combinational)
busy  output  1  1 while state is RUN
tc  output  1  terminal count flag
done  output  1  one-cycle pulse on one-shot completion
illegal  output  1  one-cycle pulse when an out-of-sequence value is corrected

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, count=0, mode_r=00, one_shot_r=0, done=0, illegal=0.
  - busy=0 and tc=0 follow from state=IDLE.
- Sequences (start value -> ... -> terminal value, then wrap to the start value):
  - up: 0..7, wrap to 0.
  - down: 7..0, wrap to 7.
  - odd-skip: 0,1,3,5,7, wrap to 0.
  - gray: 0,1,3,2,6,7,5,4, wrap to 0.
- Active mode: in IDLE it is the mode input; in RUN/DONE it is mode_r.
- nxt = successor(count, active mode).
  - In odd-skip, values 2, 4 and 6 are out of sequence; their successor is 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - count holds.
  - load=1: count<=load_val. If load_val is out of sequence for the mode input, count<=0 and illegal pulses the next cycle.
  - start=1: mode_r<=mode, one_shot_r<=one_shot, next state RUN.
    - If count (post-load value when load and start coincide) is out of sequence for mode, count<=0 and illegal pulses.
  - load and start in the same cycle are both accepted; the run begins from the loaded value.
- RUN:
  - Priority: stop > pause > advance.
  - stop: next state IDLE, count holds, no done.
  - pause: count holds, stays in RUN.
  - advance: count<=nxt, one step per clock.
  - One-shot end: if one_shot_r=1 and count==terminal, count holds and next state is DONE.
- DONE: done=1 for exactly this one cycle, then IDLE. count holds terminal.
- tc = (state==RUN) and (count==terminal of mode_r). It is combinational and independent of pause.
- start/load/mode/one_shot are ignored while busy.
- Gating of the first step: the first count change occurs one clock after RUN is entered.
- Starting at terminal in one-shot: the run completes as RUN (1 cycle) -> DONE -> IDLE.
- Continuous mode never self-terminates; only stop exits.
- Reset mid-run: immediate return to the reset values; no done is generated.

Decomposition:
- Package cnt_seq_pkg holds:
  - mode encodings MODE_UP, MODE_DOWN, MODE_ODD, MODE_GRAY;
  - state encodings ST_IDLE, ST_RUN, ST_DONE;
  - constant functions seq_start(mode), seq_terminal(mode), seq_legal(mode, value).
- Sub-module seq_next_logic: purely combinational (count, mode) -> nxt, instantiated once.
- The controller owns the FSM, registers and flags.

Test Plan:
- Odd-skip continuous: reset, mode=10, start.
  - Required count: 0,1,3,5,7,0,1.
  - tc=1 only while count=7.
  - busy stays 1; done never asserts.
- Gray one-shot: mode=11, one_shot=1, start.
  - Required count: 0,1,3,2,6,7,5,4, then holds 4.
  - done pulses one cycle after tc; busy=0 afterwards.
- Down with load: load_val=5 with load+start in the same cycle, mode=01.
  - Required count: 5,4,3,2,1,0,7,6.
  - tc=1 at count=0.
- Illegal load: mode=10, load_val=4.
  - count=0 and illegal=1 for one cycle.
  - Subsequent start then counts 0,1,3.
- Priority: during an up run at count=3, assert pause 2 cycles.
  - count holds at 3.
  - Then stop and pause together -> IDLE, count=3, done=0.
  - start/mode change while busy has no effect.
- Reset mid-run: drop rst asynchronously between clock edges at count=5.
  - count=0, busy=0, tc=0, done=0 immediately.
  - No done pulse after release.
